// File: rtl/onehot_decoder_fifo.sv
// rtl/onehot_decoder_fifo.sv - buffers encoded codes and emits them as one-hot words
// Optional saturating pop counter (dec_count) when ONEHOT_DECODER_CNT_EN is defined.
module onehot_decoder_fifo #(
    parameter int DEPTH  = 4,
    parameter int CODE_W = 2,
    localparam int OUT_W = 2 ** CODE_W,
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_onehot,
`ifdef ONEHOT_DECODER_CNT_EN
    output logic [7:0]        dec_count,
`endif
    output logic [LVL_W-1:0]  level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [CODE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push;
    logic              pop;

    // Handshake readiness depends only on registered occupancy, never on out_ready.
    assign in_ready   = (level != LVL_W'(DEPTH));
    assign out_valid  = (level != '0);
    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;
    assign out_onehot = out_valid ? (OUT_W'(1) << mem[rd_ptr]) : '0;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                level <= level + LVL_W'(1);
            end else if (pop && !push) begin
                level <= level - LVL_W'(1);
            end
        end
    end

    // Storage is unreset; the head is only observed while out_valid is high.
    always_ff @(posedge clk) begin
        if (push && !rst && !flush) begin
            mem[wr_ptr] <= in_code;
        end
    end

`ifdef ONEHOT_DECODER_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            dec_count <= '0;
        end else if (pop && (dec_count != 8'hFF)) begin
            dec_count <= dec_count + 8'd1;
        end
    end
`endif

endmodule
